// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side initiator for a 32-bit combinational ALU.
// It holds a small register file and accepts register/immediate commands over
// a valid/ready handshake. Each command is issued to the ALU for one cycle.
// The result is written back and returned over a valid/ready response channel.
// Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN adds sticky_clr/sticky_flags
// (accumulated {N,Z,C,V} of every non-NOP issue, cleared by sticky_clr).
module alu_cmd_sequencer #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 3,
   parameter int R0_ZERO    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [REG_ADDR_W-1:0] cmd_rd,
   input  logic [REG_ADDR_W-1:0] cmd_rs,
   input  logic [REG_ADDR_W-1:0] cmd_rt,
   input  logic                  cmd_imm_sel,
   input  logic [DATA_W-1:0]     cmd_imm,
   output logic [DATA_W-1:0]     alu_busA,
   output logic [DATA_W-1:0]     alu_busB,
   output logic [2:0]            alu_control,
   input  logic [DATA_W-1:0]     alu_dataOut,
   input  logic                  alu_zero,
   input  logic                  alu_overflow,
   input  logic                  alu_carryout,
   input  logic                  alu_negative,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
   input  logic                  sticky_clr,
   output logic [3:0]            sticky_flags,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [3:0]            rsp_flags
);

   localparam int RF_DEPTH = 2 ** REG_ADDR_W;
   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_CMP = 3'd6;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       rf_q [RF_DEPTH];
   logic [DATA_W-1:0]       rf_d [RF_DEPTH];
   logic [DATA_W-1:0]       alu_busA_q, alu_busA_d;
   logic [DATA_W-1:0]       alu_busB_q, alu_busB_d;
   logic [2:0]              alu_control_q, alu_control_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
   logic [3:0]              rsp_flags_q, rsp_flags_d;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
   logic [3:0]              sticky_q, sticky_d;
`endif

   logic [DATA_W-1:0]       rs_val;
   logic [DATA_W-1:0]       rt_val;
   logic [DATA_W-1:0]       result;
   logic [3:0]              flags;
   logic                    wr_en;

   // Register-file read ports (r0 optionally hard-wired to zero) and result masking.
   always_comb begin
      rs_val = rf_q[cmd_rs];
      rt_val = rf_q[cmd_rt];
      if ((R0_ZERO != 0) && (cmd_rs == '0)) rs_val = '0;
      if ((R0_ZERO != 0) && (cmd_rt == '0)) rt_val = '0;

      result = alu_dataOut;
      flags  = {alu_negative, alu_zero, alu_carryout, alu_overflow};
      if (alu_control_q == OP_NOP) begin
         result = '0;
         flags  = '0;
      end else if (alu_control_q == OP_CMP) begin
         // Compare only defines the low two bits; anything above is discarded.
         result = {{(DATA_W-2){1'b0}}, alu_dataOut[1:0]};
      end

      wr_en = (alu_control_q != OP_NOP) && !((R0_ZERO != 0) && (rd_q == '0));
   end

   // Next-state and next-output logic for the IDLE -> ISSUE -> RESP sequence.
   always_comb begin
      state_d       = state_q;
      rf_d          = rf_q;
      alu_busA_d    = alu_busA_q;
      alu_busB_d    = alu_busB_q;
      alu_control_d = alu_control_q;
      rd_d          = rd_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_flags_d   = rsp_flags_q;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      sticky_d      = sticky_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               // Operands are read here, so rs == rt == rd sees the old value.
               alu_busA_d    = rs_val;
               alu_busB_d    = cmd_imm_sel ? cmd_imm : rt_val;
               alu_control_d = cmd_op;
               rd_d          = cmd_rd;
               cmd_ready_d   = 1'b0;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            rsp_data_d    = result;
            rsp_flags_d   = flags;
            rsp_valid_d   = 1'b1;
            alu_control_d = OP_NOP;
            if (wr_en) rf_d[rd_q] = result;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            if (alu_control_q != OP_NOP) sticky_d = sticky_q | flags;
`endif
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      // A clear on the same edge as a set wins.
      if (sticky_clr) sticky_d = '0;
`endif
   end

   // State, register file and registered outputs; reset aborts any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
         alu_busA_q    <= '0;
         alu_busB_q    <= '0;
         alu_control_q <= OP_NOP;
         rd_q          <= '0;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_flags_q   <= '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
         sticky_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         rf_q          <= rf_d;
         alu_busA_q    <= alu_busA_d;
         alu_busB_q    <= alu_busB_d;
         alu_control_q <= alu_control_d;
         rd_q          <= rd_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_flags_q   <= rsp_flags_d;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
         sticky_q      <= sticky_d;
`endif
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign alu_busA    = alu_busA_q;
   assign alu_busB    = alu_busB_q;
   assign alu_control = alu_control_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_flags   = rsp_flags_q;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
   assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU stub plus a register-file reference model.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
   logic        cmd_imm_sel;
   logic [31:0] cmd_imm;
   logic [31:0] alu_busA, alu_busB, alu_dataOut;
   logic [2:0]  alu_control;
   logic        alu_zero, alu_overflow, alu_carryout, alu_negative;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_flags;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
   logic        sticky_clr;
   logic [3:0]  sticky_flags;
`endif

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [31:0] mrf [8];
   logic [35:0] alu_res;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
      .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
      .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_control(alu_control),
      .alu_dataOut(alu_dataOut), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_carryout(alu_carryout), .alu_negative(alu_negative),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags)
   );

   // Behavioural ALU: returns {N, Z, C, V, result}. NOP and COMPARE drive junk
   // where the sequencer is expected to mask.
   function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      logic [1:0]  cmp;
      w = '0; r = '0; c = 1'b0; v = 1'b0; cmp = '0;
      case (op)
         3'd0: begin r = a | b | 32'h1; c = 1'b1; v = 1'b1; end
         3'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                     v = (a[31] == b[31]) && (r[31] != a[31]); end
         3'd2: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32];
                     v = (a[31] != b[31]) && (r[31] != a[31]); end
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: begin
            cmp = ($signed(a) < $signed(b)) ? 2'b01 : ((a == b) ? 2'b10 : 2'b00);
            r = {~a[31:2], cmp};
         end
         default: r = a << b[1:0];
      endcase
      return {r[31], (r == 32'h0), c, v, r};
   endfunction

   always_comb alu_res = alu_fn(alu_control, alu_busA, alu_busB);
   assign alu_dataOut = alu_res[31:0];
   assign {alu_negative, alu_zero, alu_carryout, alu_overflow} = alu_res[35:32];

   function automatic logic [31:0] mread(input logic [2:0] idx);
      return (idx == 3'd0) ? 32'h0 : mrf[idx];
   endfunction

   // Reference model of one command: operands, response, and write-back.
   task automatic model_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic sel, input logic [31:0] imm,
                            output logic [31:0] ea, output logic [31:0] eb,
                            output logic [31:0] ed, output logic [3:0] ef);
      logic [35:0] raw;
      ea  = mread(rs);
      eb  = sel ? imm : mread(rt);
      raw = alu_fn(op, ea, eb);
      ef  = raw[35:32];
      ed  = raw[31:0];
      if (op == 3'd0) begin ed = 32'h0; ef = 4'h0; end
      else if (op == 3'd6) ed = {30'h0, raw[1:0]};
      if (op != 3'd0 && rd != 3'd0) mrf[rd] = ed;
   endtask

   // Drive one command, observe the ISSUE cycle and the response, and accept it.
   task automatic send_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic sel, input logic [31:0] imm,
                           output logic [31:0] g_a, output logic [31:0] g_b, output logic [2:0] g_ctl,
                           output logic [31:0] g_data, output logic [3:0] g_flags,
                           output int lat, output int acc_cyc);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
      cmd_imm_sel = sel; cmd_imm = imm; rsp_ready = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout cmd_ready=%b required=1", cmd_ready);
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_rs = 3'($urandom); cmd_rt = 3'($urandom);
      cmd_imm = $urandom; cmd_imm_sel = 1'($urandom);
      @(negedge clk);
      g_a = alu_busA; g_b = alu_busB; g_ctl = alu_control;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      if (lat >= 20) begin
         vectors++; miscompares++;
         $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
      end
      g_data = rsp_data; g_flags = rsp_flags;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = '0; cmd_rd = '0;
      cmd_rs = '0; cmd_rt = '0; cmd_imm_sel = 1'b0; cmd_imm = '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      sticky_clr = 1'b0;
`endif
      for (int i = 0; i < 8; i++) mrf[i] = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      vectors++; if (alu_control !== 3'b000) begin miscompares++; $display("FAIL reset_alu_control got=%b exp=000", alu_control); end
      vectors++; if (alu_busA !== 32'h0 || alu_busB !== 32'h0) begin miscompares++; $display("FAIL reset_buses got=%h/%h exp=0/0", alu_busA, alu_busB); end
      vectors++; if (rsp_data !== 32'h0 || rsp_flags !== 4'h0) begin miscompares++; $display("FAIL reset_rsp got=%h/%h exp=0/0", rsp_data, rsp_flags); end
   endtask

   task automatic test_imm_add;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac;
      model_cmd(3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'h7FFFFFFF) begin miscompares++; $display("FAIL add_load_r1 got=%h exp=7fffffff", gd); end
      model_cmd(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 32'h1, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 32'h1, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'h80000000) begin miscompares++; $display("FAIL add_ovf_data got=%h exp=80000000", gd); end
      vectors++; if (gf !== 4'b1001) begin miscompares++; $display("FAIL add_ovf_flags got=%b exp=1001", gf); end
      vectors++; if (ga !== 32'h7FFFFFFF || gb !== 32'h1 || gc !== 3'd1) begin miscompares++; $display("FAIL add_issue got=%h/%h/%0d exp=7fffffff/1/1", ga, gb, gc); end
      vectors++; if (lat != 2) begin miscompares++; $display("FAIL add_latency got=%0d exp=2", lat); end
   endtask

`ifdef ALU_SEQ_STICKY_FLAGS_EN
   task automatic test_sticky;
      @(negedge clk);
      vectors++; if (sticky_flags !== 4'b1001) begin miscompares++; $display("FAIL sticky_set got=%b exp=1001", sticky_flags); end
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      vectors++; if (sticky_flags !== 4'b0000) begin miscompares++; $display("FAIL sticky_clr got=%b exp=0000", sticky_flags); end
   endtask
`endif

   task automatic test_sub_dep;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac;
      model_cmd(3'd1, 3'd3, 3'd0, 3'd0, 1'b1, 32'd5, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd3, 3'd0, 3'd0, 1'b1, 32'd5, ga, gb, gc, gd, gf, lat, ac);
      model_cmd(3'd2, 3'd4, 3'd3, 3'd3, 1'b0, 32'h0, ea, eb, ed, ef);
      send_cmd(3'd2, 3'd4, 3'd3, 3'd3, 1'b0, 32'hDEAD, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'h0) begin miscompares++; $display("FAIL sub_zero_data got=%h exp=0", gd); end
      vectors++; if (gf[2] !== 1'b1) begin miscompares++; $display("FAIL sub_zero_flag got=%b exp=1", gf[2]); end
      model_cmd(3'd1, 3'd5, 3'd4, 3'd0, 1'b1, 32'd9, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd5, 3'd4, 3'd0, 1'b1, 32'd9, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'd9) begin miscompares++; $display("FAIL dep_add got=%h exp=9", gd); end
   endtask

   task automatic test_compare;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac;
      model_cmd(3'd1, 3'd6, 3'd0, 3'd0, 1'b1, 32'd3, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd6, 3'd0, 3'd0, 1'b1, 32'd3, ga, gb, gc, gd, gf, lat, ac);
      model_cmd(3'd6, 3'd7, 3'd6, 3'd0, 1'b1, 32'd7, ea, eb, ed, ef);
      send_cmd(3'd6, 3'd7, 3'd6, 3'd0, 1'b1, 32'd7, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'h1) begin miscompares++; $display("FAIL cmp_data got=%h exp=1", gd); end
      vectors++; if (gf !== ef) begin miscompares++; $display("FAIL cmp_flags got=%b exp=%b", gf, ef); end
   endtask

   task automatic test_backpressure;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac;
      model_cmd(3'd5, 3'd2, 3'd2, 3'd5, 1'b0, 32'h0, ea, eb, ed, ef);
      @(negedge clk);
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd5; cmd_rd = 3'd2; cmd_rs = 3'd2;
      cmd_rt = 3'd5; cmd_imm_sel = 1'b0; cmd_imm = 32'h0;
      @(posedge clk);
      #1;
      // Held command that must not be taken while the response is pending.
      cmd_op = 3'd1; cmd_rd = 3'd7; cmd_rs = 3'd0; cmd_imm_sel = 1'b1; cmd_imm = 32'h5555;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_flags !== ef || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold cyc%0d got=%b/%h/%b/%b exp=1/%h/%b/0", i, rsp_valid, rsp_data, rsp_flags, cmd_ready, ed, ef);
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      model_cmd(3'd4, 3'd0, 3'd7, 3'd0, 1'b1, 32'h0, ea, eb, ed, ef);
      send_cmd(3'd4, 3'd0, 3'd7, 3'd0, 1'b1, 32'h0, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== ed) begin miscompares++; $display("FAIL bp_no_accept r7 got=%h exp=%h", gd, ed); end
   endtask

   task automatic test_r0;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac;
      model_cmd(3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 32'h1234, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 32'h1234, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'h1234) begin miscompares++; $display("FAIL r0_write_rsp got=%h exp=1234", gd); end
      model_cmd(3'd4, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0, ea, eb, ed, ef);
      send_cmd(3'd4, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0, ga, gb, gc, gd, gf, lat, ac);
      vectors++; if (gd !== 32'h0) begin miscompares++; $display("FAIL r0_read got=%h exp=0", gd); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac0, ac1;
      model_cmd(3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h00C0FFEE, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 32'h00C0FFEE, ga, gb, gc, gd, gf, lat, ac0);
      model_cmd(3'd1, 3'd2, 3'd1, 3'd1, 1'b0, 32'h0, ea, eb, ed, ef);
      send_cmd(3'd1, 3'd2, 3'd1, 3'd1, 1'b0, 32'h0, ga, gb, gc, gd, gf, lat, ac1);
      vectors++; if (gd !== ed) begin miscompares++; $display("FAIL b2b_dep got=%h exp=%h", gd, ed); end
      vectors++; if (ac1 - ac0 != 3) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=3", ac1 - ac0); end
      model_cmd(3'd2, 3'd2, 3'd2, 3'd2, 1'b0, 32'h0, ea, eb, ed, ef);
      send_cmd(3'd2, 3'd2, 3'd2, 3'd2, 1'b0, 32'h0, ga, gb, gc, gd, gf, lat, ac0);
      vectors++; if (gd !== 32'h0 || ga !== eb) begin miscompares++; $display("FAIL b2b_same_reg got=%h/%h exp=0/%h", gd, ga, eb); end
   endtask

   task automatic test_random;
      logic [31:0] ea, eb, ed, ga, gb, gd, imm; logic [3:0] ef, gf; logic [2:0] gc, op, rd, rs, rt;
      logic sel; int lat, ac;
      logic [31:0] corner [5];
      corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFFFFFF;
      corner[3] = 32'h80000000; corner[4] = 32'hFFFFFFFF;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom); rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom);
         sel = 1'($urandom);
         imm = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         model_cmd(op, rd, rs, rt, sel, imm, ea, eb, ed, ef);
         send_cmd(op, rd, rs, rt, sel, imm, ga, gb, gc, gd, gf, lat, ac);
         vectors++;
         if (ga !== ea || gb !== eb || gc !== op) begin
            miscompares++; $display("FAIL rnd_issue #%0d got=%h/%h/%0d exp=%h/%h/%0d", i, ga, gb, gc, ea, eb, op);
         end
         vectors++;
         if (gd !== ed || gf !== ef || lat != 2) begin
            miscompares++; $display("FAIL rnd_rsp #%0d op=%0d got=%h/%b/%0d exp=%h/%b/2", i, op, gd, gf, lat, ed, ef);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] ea, eb, ed, ga, gb, gd; logic [3:0] ef, gf; logic [2:0] gc; int lat, ac;
      @(negedge clk);
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 3'd4; cmd_rs = 3'd0;
      cmd_rt = 3'd0; cmd_imm_sel = 1'b1; cmd_imm = 32'h1111;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_resp got=%b exp=1", rsp_valid); end
      #1 rst_n = 1'b0;
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0 || alu_control !== 3'b000 || rsp_data !== 32'h0) begin
         miscompares++; $display("FAIL mid_reset_out got=%b/%b/%h exp=0/000/0", rsp_valid, alu_control, rsp_data);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mrf[i] = 32'h0;
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_cmd_ready got=%b exp=1", cmd_ready); end
      for (int i = 0; i < 8; i++) begin
         model_cmd(3'd4, 3'd0, 3'(i), 3'd0, 1'b1, 32'h0, ea, eb, ed, ef);
         send_cmd(3'd4, 3'd0, 3'(i), 3'd0, 1'b1, 32'h0, ga, gb, gc, gd, gf, lat, ac);
         vectors++; if (gd !== 32'h0) begin miscompares++; $display("FAIL mid_rf_clear r%0d got=%h exp=0", i, gd); end
      end
   endtask

   initial begin
      test_reset();
      test_imm_add();
`ifdef ALU_SEQ_STICKY_FLAGS_EN
      test_sticky();
`endif
      test_sub_dep();
      test_compare();
      test_backpressure();
      test_r0();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
